phys_reg_file: RTL and testbench
================================

Name: phys_reg_file

Overview:
- Physical register file for the R10K-style out-of-order core; it is the responder side of the issue-stage register read interface.
- It returns source operand values for tags presented by the issue stage.
- It accepts result writes from the complete stage (CDB) and keeps a per-tag ready bit.
- Dispatch clears a ready bit when it allocates a destination tag, and queries ready bits for source tags.

Parameters:
- PHYS_REG_SZ, 64, number of physical registers. Must be a power of two and at least 2.
- XLEN, 32, data width of each register.
- TAG_W, $clog2(PHYS_REG_SZ), width of a physical tag. Derived; not overridable.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- is_prf_packet  in  IS_PRF_PACKET  read request: read_tag_1, read_tag_2 (TAG_W each).
- prf_is_packet  out  PRF_IS_PACKET  read response: read_out_1, read_out_2 (XLEN each).
- cdb_en  in  1  complete-stage write valid.
- cdb_tag  in  TAG_W  destination tag being written.
- cdb_value  in  XLEN  result value.
- alloc_en  in  1  dispatch allocated a destination tag this cycle.
- alloc_tag  in  TAG_W  newly allocated tag; its ready bit is cleared.
- query_tag_1, query_tag_2  in  TAG_W  dispatch source tags for the ready lookup.
- query_ready_1, query_ready_2  out  1  ready status of the query tags.

Behaviour:
- State: value array reg_val[PHYS_REG_SZ] of XLEN bits, and ready array rdy[PHYS_REG_SZ].
- Reset, asynchronous: every reg_val = 0 and every rdy = 1.
  - While reset is asserted, read_out_1 = read_out_2 = 0 and query_ready_1 = query_ready_2 = 1.
- Tag 0 is the hardwired zero register:
  - reads return 0 and ready is always 1;
  - cdb writes and alloc to tag 0 are ignored.
- Read ports are combinational, zero latency; the issue stage samples the response in the same cycle.
- Write-to-read bypass: if cdb_en is high and cdb_tag == read_tag_N != 0, then read_out_N = cdb_value in that cycle.
- Ready bypass: if cdb_en is high and cdb_tag == query_tag_N != 0, then query_ready_N = 1 in that cycle.
- Alloc query: if alloc_en is high and alloc_tag == query_tag_N, the query does NOT see the clear this cycle; the clear takes effect at the next edge.
- Write: on the rising edge with cdb_en high and cdb_tag != 0, reg_val[cdb_tag] <= cdb_value and rdy[cdb_tag] <= 1.
- Alloc: on the rising edge with alloc_en high and alloc_tag != 0, rdy[alloc_tag] <= 0. reg_val is unchanged.
- cdb write and alloc in the same cycle:
  - Different tags: both take effect independently.
  - Same tag: reg_val is updated, rdy ends at 0 (alloc wins, because the new producer owns the tag).
  - In a correct pipeline the same-tag case is a protocol error; an assertion fires in simulation, but the hardware behaviour above still holds.
- Both read ports may present the same tag; each returns an identical value.
- Reset asserted mid-operation clears the state immediately. Writes and allocs presented during reset are dropped.
- No stall or back-pressure: every request is serviced every cycle.

Decomposition:
- Shared package (sys_defs) holds:
  - PHYS_REG_SZ, XLEN, TAG_W;
  - the PHYS_TAG typedef;
  - the IS_PRF_PACKET struct (read_tag_1, read_tag_2);
  - the PRF_IS_PACKET struct (read_out_1, read_out_2).
- One natural sub-module: prf_ready_table. It owns rdy[], the alloc/cdb set-clear logic, and the two query ports with bypass.
- phys_reg_file instantiates prf_ready_table and owns the value array and the read bypass.

Test Plan:
1. Reset, then read tags 5 and 63 -> read_out_1 = read_out_2 = 0, and query_ready for tags 5 and 63 = 1.
2. alloc tag 7, next cycle query tag 7 -> ready = 0. Then cdb write 7 = 0xDEADBEEF with read_tag_1 = 7 the same cycle -> read_out_1 = 0xDEADBEEF and query_ready = 1 that cycle; both remain after the edge.
3. cdb write tag 0 = 0x1234, then read tag 0 -> 0; query tag 0 -> 1. alloc tag 0 -> query tag 0 still reads 1.
4. Same cycle: cdb write tag 9 = 0x55 and alloc tag 9 -> next cycle reg 9 = 0x55, ready 0, and the assertion fires.
5. Write tags 1..63 with value tag*3, then read pairs (1,63) and (62,62) -> 3/189 and 186/186.
6. Write tag 12 = 0xA5, then assert reset mid-cycle asynchronously -> read_out for tag 12 immediately drops to 0 and ready = 1.

Source files
------------

// File: rtl/sys_defs.sv
// Shared physical-register-file types: sizing constants, the physical tag
// and the issue-stage read request/response packets.
package sys_defs;

  localparam int PHYS_REG_SZ = 64;
  localparam int XLEN        = 32;
  localparam int TAG_W       = $clog2(PHYS_REG_SZ);

  typedef logic [TAG_W-1:0] PHYS_TAG;

  typedef struct packed {
    PHYS_TAG read_tag_1;
    PHYS_TAG read_tag_2;
  } IS_PRF_PACKET;

  typedef struct packed {
    logic [XLEN-1:0] read_out_1;
    logic [XLEN-1:0] read_out_2;
  } PRF_IS_PACKET;

endpackage

// File: rtl/prf_ready_table.sv
// Per-tag ready bits: dispatch clears a bit on allocation, the CDB sets it on
// completion, and two dispatch query ports see a same-cycle CDB set.
module prf_ready_table
  import sys_defs::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    cdb_en,
  input  PHYS_TAG cdb_tag,
  input  logic    alloc_en,
  input  PHYS_TAG alloc_tag,
  input  PHYS_TAG query_tag_1,
  input  PHYS_TAG query_tag_2,
  output logic    query_ready_1,
  output logic    query_ready_2
);

  logic [PHYS_REG_SZ-1:0] rdy_q;
  logic [PHYS_REG_SZ-1:0] rdy_d;

  // Alloc is applied after the CDB set so a same-tag collision leaves the
  // bit cleared: the newly allocated producer owns the tag.
  always_comb begin
    rdy_d = rdy_q;
    if (cdb_en && (cdb_tag != '0)) begin
      rdy_d[cdb_tag] = 1'b1;
    end
    if (alloc_en && (alloc_tag != '0)) begin
      rdy_d[alloc_tag] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q <= '1;
    end else begin
      rdy_q <= rdy_d;
    end
  end

  // A pending alloc is deliberately not visible here until the next edge.
  always_comb begin
    query_ready_1 = (query_tag_1 == '0) || rdy_q[query_tag_1] ||
                    (cdb_en && (cdb_tag == query_tag_1));
    query_ready_2 = (query_tag_2 == '0) || rdy_q[query_tag_2] ||
                    (cdb_en && (cdb_tag == query_tag_2));
  end

endmodule

// File: rtl/phys_reg_file.sv
// Physical register file: value storage with CDB write-to-read bypass on two
// issue read ports, plus the ready table used by dispatch.
module phys_reg_file
  import sys_defs::*;
(
  input  logic            clock,
  input  logic            reset,
  input  IS_PRF_PACKET    is_prf_packet,
  output PRF_IS_PACKET    prf_is_packet,
  input  logic            cdb_en,
  input  PHYS_TAG         cdb_tag,
  input  logic [XLEN-1:0] cdb_value,
  input  logic            alloc_en,
  input  PHYS_TAG         alloc_tag,
  input  PHYS_TAG         query_tag_1,
  input  PHYS_TAG         query_tag_2,
  output logic            query_ready_1,
  output logic            query_ready_2
);

  logic [PHYS_REG_SZ-1:0][XLEN-1:0] reg_val_q;
  logic [PHYS_REG_SZ-1:0][XLEN-1:0] reg_val_d;

  always_comb begin
    reg_val_d = reg_val_q;
    if (cdb_en && (cdb_tag != '0)) begin
      reg_val_d[cdb_tag] = cdb_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_val_q <= '0;
    end else begin
      reg_val_q <= reg_val_d;
    end
  end

  // Reset forces zero even if a CDB write is presented, since it is dropped.
  always_comb begin
    prf_is_packet = '0;
    if (!reset && (is_prf_packet.read_tag_1 != '0)) begin
      if (cdb_en && (cdb_tag == is_prf_packet.read_tag_1)) begin
        prf_is_packet.read_out_1 = cdb_value;
      end else begin
        prf_is_packet.read_out_1 = reg_val_q[is_prf_packet.read_tag_1];
      end
    end
    if (!reset && (is_prf_packet.read_tag_2 != '0)) begin
      if (cdb_en && (cdb_tag == is_prf_packet.read_tag_2)) begin
        prf_is_packet.read_out_2 = cdb_value;
      end else begin
        prf_is_packet.read_out_2 = reg_val_q[is_prf_packet.read_tag_2];
      end
    end
  end

  prf_ready_table u_ready_table (
    .clock         (clock),
    .reset         (reset),
    .cdb_en        (cdb_en),
    .cdb_tag       (cdb_tag),
    .alloc_en      (alloc_en),
    .alloc_tag     (alloc_tag),
    .query_tag_1   (query_tag_1),
    .query_tag_2   (query_tag_2),
    .query_ready_1 (query_ready_1),
    .query_ready_2 (query_ready_2)
  );

  // Completing and re-allocating the same tag in one cycle means the
  // pipeline freed a tag that still had an outstanding producer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(cdb_en && alloc_en && (cdb_tag == alloc_tag) && (cdb_tag != '0)))
        else $warning("phys_reg_file: cdb write and alloc hit tag %0d together", cdb_tag);
    end
  end

endmodule

// File: tb/tb_phys_reg_file.sv
// Scoreboard bench for phys_reg_file: stimulus pushes model expectations,
// a monitor pops and compares the combinational response each cycle.
module tb_phys_reg_file;
  import sys_defs::*;

  logic            clock = 1'b0;
  logic            reset;
  IS_PRF_PACKET    is_prf_packet;
  PRF_IS_PACKET    prf_is_packet;
  logic            cdb_en;
  PHYS_TAG         cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic            alloc_en;
  PHYS_TAG         alloc_tag;
  PHYS_TAG         query_tag_1;
  PHYS_TAG         query_tag_2;
  logic            query_ready_1;
  logic            query_ready_2;

  typedef struct {
    string           name;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic            q1;
    logic            q2;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [XLEN-1:0] model_val [PHYS_REG_SZ];
  bit              model_rdy [PHYS_REG_SZ];

  always #5 clock = ~clock;

  phys_reg_file dut (
    .clock         (clock),
    .reset         (reset),
    .is_prf_packet (is_prf_packet),
    .prf_is_packet (prf_is_packet),
    .cdb_en        (cdb_en),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .alloc_en      (alloc_en),
    .alloc_tag     (alloc_tag),
    .query_tag_1   (query_tag_1),
    .query_tag_2   (query_tag_2),
    .query_ready_1 (query_ready_1),
    .query_ready_2 (query_ready_2)
  );

  function automatic void modelReset();
    for (int i = 0; i < PHYS_REG_SZ; i++) begin
      model_val[i] = '0;
      model_rdy[i] = 1'b1;
    end
  endfunction

  function automatic logic [XLEN-1:0] modelRead(input logic rst_v, input logic c_en,
                                                input int c_tag, input logic [XLEN-1:0] c_val,
                                                input int t);
    if (rst_v || t == 0) return '0;
    if (c_en && c_tag == t) return c_val;
    return model_val[t];
  endfunction

  function automatic logic modelReady(input logic rst_v, input logic c_en,
                                      input int c_tag, input int t);
    if (rst_v || t == 0) return 1'b1;
    if (c_en && c_tag == t) return 1'b1;
    return model_rdy[t];
  endfunction

  // Drives one cycle of stimulus at the falling edge, queues the expected
  // response, then advances the model to its post-rising-edge state.
  task automatic applyStimulus(input string name, input logic rst_v,
                               input logic c_en, input int c_tag, input logic [XLEN-1:0] c_val,
                               input logic a_en, input int a_tag,
                               input int rt1, input int rt2, input int qt1, input int qt2);
    exp_t e;
    @(negedge clock);
    reset                    = rst_v;
    cdb_en                   = c_en;
    cdb_tag                  = PHYS_TAG'(c_tag);
    cdb_value                = c_val;
    alloc_en                 = a_en;
    alloc_tag                = PHYS_TAG'(a_tag);
    is_prf_packet.read_tag_1 = PHYS_TAG'(rt1);
    is_prf_packet.read_tag_2 = PHYS_TAG'(rt2);
    query_tag_1              = PHYS_TAG'(qt1);
    query_tag_2              = PHYS_TAG'(qt2);
    e.name = name;
    e.r1   = modelRead(rst_v, c_en, c_tag, c_val, rt1);
    e.r2   = modelRead(rst_v, c_en, c_tag, c_val, rt2);
    e.q1   = modelReady(rst_v, c_en, c_tag, qt1);
    e.q2   = modelReady(rst_v, c_en, c_tag, qt2);
    exp_q.push_back(e);
    if (rst_v) begin
      modelReset();
    end else begin
      if (c_en && c_tag != 0) begin
        model_val[c_tag] = c_val;
        model_rdy[c_tag] = 1'b1;
      end
      if (a_en && a_tag != 0) model_rdy[a_tag] = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_r1"}, prf_is_packet.read_out_1, e.r1);
        checkOutput({e.name, "_r2"}, prf_is_packet.read_out_2, e.r2);
        checkOutput({e.name, "_q1"}, XLEN'(query_ready_1), XLEN'(e.q1));
        checkOutput({e.name, "_q2"}, XLEN'(query_ready_2), XLEN'(e.q2));
      end
    end
  end

  initial begin : stimulus
    int c_tag, a_tag;
    logic c_en, a_en, r_v;
    reset         = 1'b1;
    cdb_en        = 1'b0;
    cdb_tag       = '0;
    cdb_value     = '0;
    alloc_en      = 1'b0;
    alloc_tag     = '0;
    is_prf_packet = '0;
    query_tag_1   = '0;
    query_tag_2   = '0;
    modelReset();

    applyStimulus("t1_in_reset", 1, 0, 0, 0, 0, 0, 5, 63, 5, 63);
    applyStimulus("t1_after_reset", 0, 0, 0, 0, 0, 0, 5, 63, 5, 63);

    applyStimulus("t2_alloc", 0, 0, 0, 0, 1, 7, 7, 0, 7, 7);
    applyStimulus("t2_cleared", 0, 0, 0, 0, 0, 0, 7, 7, 7, 0);
    applyStimulus("t2_cdb_bypass", 0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0, 7, 0);
    applyStimulus("t2_after_write", 0, 0, 0, 0, 0, 0, 7, 7, 7, 7);

    applyStimulus("t3_cdb_tag0", 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    applyStimulus("t3_read_tag0", 0, 0, 0, 0, 0, 0, 0, 7, 0, 7);
    applyStimulus("t3_alloc_tag0", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("t3_query_tag0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("t4_collide", 0, 1, 9, 32'h55, 1, 9, 9, 0, 9, 0);
    applyStimulus("t4_after", 0, 0, 0, 0, 0, 0, 9, 9, 9, 9);

    for (int t = 1; t < PHYS_REG_SZ; t++) begin
      applyStimulus("t5_fill", 0, 1, t, XLEN'(t * 3), 0, 0, t, 0, t, 0);
    end
    applyStimulus("t5_pair_1_63", 0, 0, 0, 0, 0, 0, 1, 63, 1, 63);
    applyStimulus("t5_pair_62_62", 0, 0, 0, 0, 0, 0, 62, 62, 62, 62);

    applyStimulus("t6_write12", 0, 1, 12, 32'hA5, 1, 20, 0, 0, 0, 0);
    applyStimulus("t6_read12", 0, 0, 0, 0, 0, 0, 12, 12, 12, 20);
    applyStimulus("t6_reset_mid", 1, 1, 12, 32'hFFFF_FFFF, 1, 12, 12, 12, 12, 20);
    applyStimulus("t6_reset_hold", 1, 0, 0, 0, 0, 0, 12, 20, 12, 20);
    applyStimulus("t6_released", 0, 0, 0, 0, 0, 0, 12, 1, 12, 20);

    for (int i = 0; i < 600; i++) begin
      c_en  = 1'($urandom_range(0, 1));
      a_en  = 1'($urandom_range(0, 1));
      c_tag = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      a_tag = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      if (c_en && a_en && c_tag == a_tag) a_en = 1'b0;
      r_v   = ($urandom_range(0, 149) == 0);
      applyStimulus("rand", r_v, c_en, c_tag, $urandom, a_en, a_tag,
                    $urandom_range(0, 7), $urandom_range(0, 63),
                    $urandom_range(0, 7), $urandom_range(0, 63));
    end

    applyStimulus("final_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
